fanfare_gen: RTL and testbench

FANFARE_GEN -- requirements
Module: fanfare_gen

---
 rtl/fanfare_gen.sv | 128 ++++++++++++
 tb/tb_fanfare_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fanfare_gen.sv
// fanfare_gen -- plays a six-note fanfare (G6 C7 E7 G7 E7 G7) on a piezo
// buzzer when the command processor signals that a move has completed.
//
// Ports
//   clk      system clock (50 MHz). All state changes on the rising edge.
//   rst      asynchronous, active-high reset. Aborts playback without a done pulse.
//   go       one-clock request to start the fanfare. It is ignored while playing,
//            and also on the cycle that done is high.
//   piezo    square-wave drive to the buzzer. It is 0 when idle.
//   piezo_n  complement drive. It equals ~piezo while busy and is 0 when idle.
//   busy     high while a fanfare is playing.
//   done     one-clock pulse on the first idle cycle after the last note.
//
// Parameters
//   FAST_SIM   nonzero: the duration counter advances 16 per clock. Zero: 1 per clock.
//   DUR_SHIFT  right-shift applied to every note duration (0 in hardware).
//   PER_SHIFT  right-shift applied to every tone period (0 in hardware).
//              Both shifts let a simulation compress the whole sequence.
module fanfare_gen #(
    parameter int FAST_SIM  = 1,
    parameter int DUR_SHIFT = 0,
    parameter int PER_SHIFT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic piezo,
    output logic piezo_n,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE, S_G6, S_C7, S_E7A, S_G7A, S_E7B, S_G7B
    } state_t;

    localparam logic [25:0] INC = (FAST_SIM != 0) ? 26'd16 : 26'd1;

    // Note durations, in duration-counter units.
    function automatic logic [25:0] note_dur(input state_t s);
        case (s)
            S_G6, S_C7, S_E7A: note_dur = 26'h0800000 >> DUR_SHIFT;
            S_G7A:             note_dur = 26'h0C00000 >> DUR_SHIFT;
            S_E7B:             note_dur = 26'h0400000 >> DUR_SHIFT;
            S_G7B:             note_dur = 26'h1000000 >> DUR_SHIFT;
            default:           note_dur = 26'd1;
        endcase
    endfunction

    // Full tone periods, in clocks.
    function automatic logic [14:0] note_per(input state_t s);
        case (s)
            S_G6:         note_per = 15'd31888 >> PER_SHIFT;
            S_C7:         note_per = 15'd23889 >> PER_SHIFT;
            S_E7A, S_E7B: note_per = 15'd18961 >> PER_SHIFT;
            S_G7A, S_G7B: note_per = 15'd15944 >> PER_SHIFT;
            default:      note_per = 15'd1;
        endcase
    endfunction

    function automatic state_t next_note(input state_t s);
        case (s)
            S_G6:    next_note = S_C7;
            S_C7:    next_note = S_E7A;
            S_E7A:   next_note = S_G7A;
            S_G7A:   next_note = S_E7B;
            S_E7B:   next_note = S_G7B;
            default: next_note = S_IDLE;
        endcase
    endfunction

    state_t      state, state_nx;
    logic [24:0] dcnt, dcnt_nx;
    logic [14:0] pcnt, pcnt_nx;
    logic [25:0] dsum;
    logic        done_nx, busy_nx, tone_nx;

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        pcnt_nx  = pcnt;
        done_nx  = 1'b0;
        dsum     = {1'b0, dcnt} + INC;

        if (state == S_IDLE) begin
            // A go that lands on the done cycle is treated as stale.
            if (go && !done) begin
                state_nx = S_G6;
                dcnt_nx  = '0;
                pcnt_nx  = '0;
            end
        end else if (dsum >= note_dur(state)) begin
            state_nx = next_note(state);
            dcnt_nx  = '0;
            pcnt_nx  = '0;
            done_nx  = (state == S_G7B);
        end else begin
            dcnt_nx = dsum[24:0];
            pcnt_nx = (pcnt == note_per(state) - 15'd1) ? '0 : pcnt + 15'd1;
        end

        // The outputs are registered from the next-state values. This way the
        // first cycle of a note already shows the high half of its waveform.
        busy_nx = (state_nx != S_IDLE);
        tone_nx = (pcnt_nx < (note_per(state_nx) >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            dcnt    <= '0;
            pcnt    <= '0;
            piezo   <= 1'b0;
            piezo_n <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            dcnt    <= dcnt_nx;
            pcnt    <= pcnt_nx;
            piezo   <= busy_nx & tone_nx;
            piezo_n <= busy_nx & ~tone_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_fanfare_gen.sv
module tb_fanfare_gen;

    localparam int DS = 9;
    localparam int PS = 4;

    logic clk = 1'b0;
    logic rst;
    logic go;
    logic piezo, piezo_n, busy, done;

    int total = 0;
    int bad   = 0;

    fanfare_gen #(.FAST_SIM(1), .DUR_SHIFT(DS), .PER_SHIFT(PS)) dut (
        .clk(clk), .rst(rst), .go(go),
        .piezo(piezo), .piezo_n(piezo_n), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    // Reference model: the note table, and the playback position in cycles.
    int dur[6] = '{1 << 23, 1 << 23, 1 << 23, (1 << 23) + (1 << 22), 1 << 22, 1 << 24};
    int per[6] = '{31888, 23889, 18961, 15944, 18961, 15944};
    int len[6];
    int fan_len;
    bit m_play, m_done;
    int m_t;

    function automatic bit model_tone(input int t);
        int s = 0;
        for (int i = 0; i < 6; i++) begin
            if (t < s + len[i]) begin
                int p = per[i] >> PS;
                return ((t - s) % p) < (p / 2);
            end
            s += len[i];
        end
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_out();
        bit tn = m_play && model_tone(m_t);
        return {m_play, m_done, tn, m_play && !tn};
    endfunction

    // Drive go for one clock, let the model follow the same edge, and
    // return the expected {busy, done, piezo, piezo_n} for after that edge.
    task automatic cycle(input bit g, output logic [3:0] e);
        bit pd;
        go = g;
        @(posedge clk);
        pd = m_done;
        m_done = 1'b0;
        if (m_play) begin
            m_t++;
            if (m_t == fan_len) begin
                m_play = 1'b0;
                m_done = 1'b1;
            end
        end else if (g && !pd) begin
            m_play = 1'b1;
            m_t = 0;
        end
        #1;
        go = 1'b0;
        e = model_out();
    endtask

    task automatic test_reset();
        logic [3:0] e;
        rst = 1'b1;
        go  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, piezo, piezo_n} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state got=%b want=0000", {busy, done, piezo, piezo_n});
        end
        rst = 1'b0;
        m_play = 1'b0; m_done = 1'b0; m_t = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, e);
            total++;
            if ({busy, done, piezo, piezo_n} !== e) begin
                bad++;
                $display("FAIL idle cyc=%0d got=%b want=%b", i, {busy, done, piezo, piezo_n}, e);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] e;
        int done_at = -1;
        int ndone = 0;
        for (int i = 0; i < fan_len + 20; i++) begin
            cycle(i == 0, e);
            if (done === 1'b1) begin
                ndone++;
                done_at = i;
            end
            total++;
            if ({busy, done, piezo, piezo_n} !== e) begin
                bad++;
                $display("FAIL single cyc=%0d got=%b want=%b", i, {busy, done, piezo, piezo_n}, e);
            end
        end
        total++;
        if (ndone != 1 || done_at != fan_len) begin
            bad++;
            $display("FAIL single_done count=%0d at=%0d want count=1 at=%0d", ndone, done_at, fan_len);
        end
    endtask

    task automatic test_go_while_busy();
        logic [3:0] e;
        int regoes = $urandom_range(10, fan_len - 10);
        int ndone = 0;
        for (int i = 0; i < fan_len + 20; i++) begin
            bit g = (i == 0) || (i == regoes) || (i > 0 && i < fan_len && $urandom_range(0, 99) == 0);
            cycle(g, e);
            if (done === 1'b1) ndone++;
            total++;
            if ({busy, done, piezo, piezo_n} !== e) begin
                bad++;
                $display("FAIL busy_go cyc=%0d got=%b want=%b", i, {busy, done, piezo, piezo_n}, e);
            end
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL busy_go_done count=%0d want=1", ndone);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        int cut = $urandom_range(100, fan_len - 100);
        for (int i = 0; i < cut; i++) begin
            cycle(i == 0, e);
            total++;
            if ({busy, done, piezo, piezo_n} !== e) begin
                bad++;
                $display("FAIL pre_rst cyc=%0d got=%b want=%b", i, {busy, done, piezo, piezo_n}, e);
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, piezo, piezo_n} !== 4'b0000) begin
            bad++;
            $display("FAIL async_rst got=%b want=0000", {busy, done, piezo, piezo_n});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_play = 1'b0; m_done = 1'b0; m_t = 0;
        for (int i = 0; i < fan_len + 100; i++) begin
            cycle(i == 50, e);
            total++;
            if ({busy, done, piezo, piezo_n} !== e) begin
                bad++;
                $display("FAIL post_rst cyc=%0d got=%b want=%b", i, {busy, done, piezo, piezo_n}, e);
            end
        end
    endtask

    task automatic test_go_on_done();
        logic [3:0] e;
        int guard = 0;
        cycle(1'b1, e);
        while (!m_done && guard < fan_len + 10) begin
            cycle(1'b0, e);
            guard++;
            total++;
            if ({busy, done, piezo, piezo_n} !== e) begin
                bad++;
                $display("FAIL to_done cyc=%0d got=%b want=%b", guard, {busy, done, piezo, piezo_n}, e);
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_seen got=%b want=1", done);
        end
        // go lands on the done cycle and must be dropped.
        cycle(1'b1, e);
        total++;
        if ({busy, done, piezo, piezo_n} !== 4'b0000 || e !== 4'b0000) begin
            bad++;
            $display("FAIL go_on_done got=%b want=0000", {busy, done, piezo, piezo_n});
        end
        for (int i = 0; i < fan_len + 10; i++) begin
            cycle(i == 0, e);
            total++;
            if ({busy, done, piezo, piezo_n} !== e) begin
                bad++;
                $display("FAIL replay cyc=%0d got=%b want=%b", i, {busy, done, piezo, piezo_n}, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        go  = 1'b0;
        fan_len = 0;
        for (int i = 0; i < 6; i++) begin
            len[i] = ((dur[i] >> DS) + 15) / 16;
            fan_len += len[i];
        end
        test_reset();
        test_single();
        test_go_while_busy();
        test_reset_mid();
        test_go_on_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
